ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 110 +++++++++++
 tb/tb_ifetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch FSM with a 2-entry {pc, inst} buffer toward decode.
// Supports redirect, halt and word-addressed sequential fetch.
`default_nettype none

module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_rena,
    output logic        im_wena,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] tail_pc;
    logic [31:0] tail_inst;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic        pop;
    logic        issue;

    assign pop   = inst_valid & inst_ready;
    assign issue = (state == FETCH) & ~redirect_valid & ~halt_req & ((count < 2'd2) | pop);

    assign im_wena = 1'b0;
    assign im_rena = issue;
    assign im_addr = pc;

    always_comb begin
        count_nxt = count;
        if (redirect_valid) begin
            count_nxt = 2'd0;
        end else begin
            case ({issue, pop})
                2'b10:   count_nxt = count + 2'd1;
                2'b01:   count_nxt = count - 2'd1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            count      <= 2'd0;
            inst_valid <= 1'b0;
            inst_data  <= 32'd0;
            inst_pc    <= 32'd0;
            tail_pc    <= 32'd0;
            tail_inst  <= 32'd0;
            fetch_cnt  <= 32'd0;
        end else begin
            count      <= count_nxt;
            inst_valid <= (count_nxt != 2'd0);
            if (redirect_valid) begin
                // Redirect wins over halt and drops any in-flight pop.
                pc    <= redirect_pc;
                state <= FETCH;
            end else begin
                case (state)
                    IDLE:    state <= halt_req ? HALTED : FETCH;
                    FETCH:   if (halt_req) state <= HALTED;
                    HALTED:  state <= HALTED;
                    default: state <= IDLE;
                endcase

                if (issue) begin
                    pc        <= pc + ADDR_STEP;
                    fetch_cnt <= fetch_cnt + 32'd1;
                end

                // Head entry drives the decode outputs directly; tail backs it up.
                if (issue && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                    inst_pc   <= pc;
                    inst_data <= im_data;
                end else if (pop) begin
                    inst_pc   <= tail_pc;
                    inst_data <= tail_inst;
                end

                if (issue && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop))) begin
                    tail_pc   <= pc;
                    tail_inst <= im_data;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed vector table plus hand sequences for ifetch_unit.
// Memory model returns word[n] = n + 100.
`default_nettype none

module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        im_rena, im_wena;
    logic [31:0] im_addr, im_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data, inst_pc, fetch_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign im_data = im_addr + 32'd100;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_STEP(32'd1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .im_rena        (im_rena),
        .im_wena        (im_wena),
        .im_addr        (im_addr),
        .im_data        (im_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_cnt      (fetch_cnt)
    );

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        redir;
        logic        halt;
        logic [31:0] rpc;
        logic        e_rena;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_data;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rdy, input logic rd, input logic h,
                       input logic [31:0] rp, input logic rena, input logic [31:0] addr,
                       input logic vld, input logic [31:0] ipc, input logic [31:0] idat,
                       input logic [31:0] cnt);
        vec_t v;
        v.rst_n = r;  v.ready = rdy; v.redir = rd; v.halt = h; v.rpc = rp;
        v.e_rena = rena; v.e_addr = addr; v.e_valid = vld;
        v.e_pc = ipc; v.e_data = idat; v.e_cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Stream from reset with decode always ready.
        add(0,1,0,0,0,          0,32'h0,        0,0,0,0);
        add(1,1,0,0,0,          0,32'h0,        0,0,0,0);
        add(1,1,0,0,0,          1,32'h0,        0,0,0,0);
        add(1,1,0,0,0,          1,32'h1,        1,32'h0,32'd100,1);
        add(1,1,0,0,0,          1,32'h2,        1,32'h1,32'd101,2);
        add(1,1,0,0,0,          1,32'h3,        1,32'h2,32'd102,3);
        add(1,1,0,0,0,          1,32'h4,        1,32'h3,32'd103,4);
        // Reset, then stall decode for 5 cycles.
        add(0,0,0,0,0,          0,32'h0,        0,0,0,0);
        add(1,0,0,0,0,          0,32'h0,        0,0,0,0);
        add(1,0,0,0,0,          1,32'h0,        0,0,0,0);
        add(1,0,0,0,0,          1,32'h1,        1,32'h0,32'd100,1);
        add(1,0,0,0,0,          0,32'h2,        1,32'h0,32'd100,2);
        add(1,0,0,0,0,          0,32'h2,        1,32'h0,32'd100,2);
        add(1,0,0,0,0,          0,32'h2,        1,32'h0,32'd100,2);
        add(1,1,0,0,0,          1,32'h2,        1,32'h0,32'd100,2);
        add(1,1,0,0,0,          1,32'h3,        1,32'h1,32'd101,3);
        add(1,1,0,0,0,          1,32'h4,        1,32'h2,32'd102,4);
        // Redirect with buffer full.
        add(1,0,1,0,32'h40,     0,32'h5,        1,32'h3,32'd103,5);
        add(1,1,0,0,0,          1,32'h40,       0,0,0,5);
        add(1,1,0,0,0,          1,32'h41,       1,32'h40,32'h40+32'd100,6);
        // One-cycle halt, drain, stay halted, redirect to 8.
        add(1,1,0,1,0,          0,32'h42,       1,32'h41,32'h41+32'd100,7);
        add(1,1,0,0,0,          0,32'h42,       0,0,0,7);
        add(1,1,0,0,0,          0,32'h42,       0,0,0,7);
        add(1,1,1,0,32'h8,      0,32'h42,       0,0,0,7);
        add(1,1,0,0,0,          1,32'h8,        0,0,0,7);
        add(1,1,0,0,0,          1,32'h9,        1,32'h8,32'd108,8);
        // PC wrap.
        add(1,1,1,0,32'hFFFF_FFFF, 0,32'hA,     1,32'h9,32'd109,9);
        add(1,1,0,0,0,          1,32'hFFFF_FFFF,0,0,0,9);
        add(1,1,0,0,0,          1,32'h0,        1,32'hFFFF_FFFF,32'd99,10);
        // Fill two entries, then reset.
        add(1,0,0,0,0,          1,32'h1,        1,32'h0,32'd100,11);
        add(1,0,0,0,0,          0,32'h2,        1,32'h0,32'd100,12);
        add(0,1,0,0,0,          0,32'h0,        0,0,0,0);
        add(1,1,0,0,0,          0,32'h0,        0,0,0,0);
        add(1,1,0,0,0,          1,32'h0,        0,0,0,0);
        add(1,1,0,0,0,          1,32'h1,        1,32'h0,32'd100,1);
        // Halt held across reset release goes straight to HALTED.
        add(0,1,0,1,0,          0,32'h0,        0,0,0,0);
        add(1,1,0,1,0,          0,32'h0,        0,0,0,0);
        add(1,1,0,0,0,          0,32'h0,        0,0,0,0);
        add(1,1,0,0,0,          0,32'h0,        0,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst_n          = vecs[i].rst_n;
            inst_ready     = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            halt_req       = vecs[i].halt;
            redirect_pc    = vecs[i].rpc;
            #1;
            check("im_rena",    i, {31'd0, im_rena},    {31'd0, vecs[i].e_rena});
            check("im_wena",    i, {31'd0, im_wena},    32'd0);
            check("im_addr",    i, im_addr,             vecs[i].e_addr);
            check("inst_valid", i, {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
            check("fetch_cnt",  i, fetch_cnt,           vecs[i].e_cnt);
            if (vecs[i].e_valid || !vecs[i].rst_n) begin
                check("inst_pc",   i, inst_pc,   vecs[i].e_pc);
                check("inst_data", i, inst_data, vecs[i].e_data);
            end
            @(posedge clk);
            #1;
        end

        // Leave HALTED via redirect, buffer two words, then reset between edges.
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        check("seq_valid", 100, {31'd0, inst_valid}, 32'd1);
        check("seq_pc",    100, inst_pc,             32'h100);
        check("seq_rena",  100, {31'd0, im_rena},    32'd0);
        check("seq_cnt",   100, fetch_cnt,           32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 101, {31'd0, inst_valid}, 32'd0);
        check("async_pc",    101, inst_pc,             32'd0);
        check("async_cnt",   101, fetch_cnt,           32'd0);
        check("async_addr",  101, im_addr,             32'd0);
        check("async_wena",  101, {31'd0, im_wena},    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
